// File: rtl/dmux4x16_pkg.sv
// dmux4x16_pkg: shared widths, types and the one-hot register-select decode
// used by dmux4x16_dec_core and dmux4x16_regsel.
package dmux4x16_pkg;

   localparam int unsigned SEL_W = 4;
   localparam int unsigned OUT_W = 1 << SEL_W;

   typedef logic [SEL_W-1:0] sel_t;
   typedef logic [OUT_W-1:0] onehot_t;

   // One-hot decode of sel, all-zero when en is low
   function automatic onehot_t decode(input logic en, input sel_t sel);
      onehot_t r;
      r = '0;
      if (en) begin
         r[sel] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dmux4x16_dec_core.sv
// dmux4x16_dec_core: purely combinational en/sel -> one-hot decode.
// At the package width it uses dmux4x16_pkg::decode; other widths use an
// equivalent compare loop so the core stays usable if SEL_W is overridden.
module dmux4x16_dec_core
   import dmux4x16_pkg::*;
#(
   parameter int unsigned SEL_W = 4
) (
   input  logic                      en,
   input  logic [SEL_W-1:0]          sel,
   output logic [(1 << SEL_W)-1:0]   next_d
);

   localparam int unsigned OUT_W = 1 << SEL_W;

   if (SEL_W == dmux4x16_pkg::SEL_W) begin : g_pkg
      // Package decode at the native 4-to-16 width
      always_comb begin
         next_d = decode(en, sel);
      end
   end else begin : g_generic
      // Generic decode: bit i set when enabled and sel equals i
      always_comb begin
         next_d = '0;
         for (int unsigned i = 0; i < OUT_W; i++) begin
            if (en && (sel == SEL_W'(i))) begin
               next_d[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dmux4x16_regsel.sv
// dmux4x16_regsel: register-select demultiplexer, one-hot decode of a 4-bit
// register index into 16 select lines qualified by en.
// Build option: define DMUX4X16_COMB_OUT_EN for a combinational, zero-latency
// output (clk/rst unused); default build registers d with async active-high reset.
module dmux4x16_regsel
   import dmux4x16_pkg::*;
#(
   parameter int unsigned SEL_W = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [SEL_W-1:0]          sel,
   output logic [(1 << SEL_W)-1:0]   d
);

   localparam int unsigned OUT_W = 1 << SEL_W;

   logic [OUT_W-1:0] next_d;

   dmux4x16_dec_core #(
      .SEL_W (SEL_W)
   ) u_dec_core (
      .en     (en),
      .sel    (sel),
      .next_d (next_d)
   );

`ifdef DMUX4X16_COMB_OUT_EN
   // clk and rst do not affect the output in the combinational build
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;

   // Output follows the decode directly
   always_comb begin
      d = next_d;
   end
`else
   logic [OUT_W-1:0] d_d;
   logic [OUT_W-1:0] d_q;

   // Next-state for the output register is the current decode
   always_comb begin
      d_d = next_d;
   end

   // Output register; reset clears it immediately and discards any pending decode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_q <= '0;
      end else begin
         d_q <= d_d;
      end
   end

   // Drive the port from the register
   always_comb begin
      d = d_q;
   end
`endif

endmodule

// File: tb/tb_dmux4x16_regsel.sv
// tb_dmux4x16_regsel: directed self-checking bench for dmux4x16_regsel.
// Works for both builds; define DMUX4X16_COMB_OUT_EN to check the
// combinational variant.
module tb_dmux4x16_regsel;

   logic        clk;
   logic        rst;
   logic        en;
   logic [3:0]  sel;
   logic [15:0] d;

   int errors;
   int checks;

   dmux4x16_regsel #(
      .SEL_W (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .sel (sel),
      .d   (d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wait until the last driven inputs are visible on d
   task automatic settle();
`ifdef DMUX4X16_COMB_OUT_EN
      #1;
`else
      @(posedge clk);
      #1;
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b0;
      sel = 4'd0;
      #12;
      checks++;
      if (d !== 16'h0000) begin
         errors++;
         $display("FAIL reset_hold: d=%h expected=%h", d, 16'h0000);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      settle();
      checks++;
      if (d !== 16'h0000) begin
         errors++;
         $display("FAIL reset_release_en0: d=%h expected=%h", d, 16'h0000);
      end
   endtask

   task automatic test_sweep();
      logic [15:0] exp_d;
      exp_d = 16'h0001;
      en = 1'b1;
      for (int i = 1; i < 16; i++) begin
         sel   = 4'(i);
         exp_d = exp_d << 1;
`ifndef DMUX4X16_COMB_OUT_EN
         // Registered build: before the edge d still shows the previous index
         #1;
         checks++;
         if (d === exp_d) begin
            errors++;
            $display("FAIL sweep_latency sel=%0d: d=%h changed before the clock edge", i, d);
         end
`endif
         settle();
         checks++;
         if (d !== exp_d || $countones(d) != 1) begin
            errors++;
            $display("FAIL sweep sel=%0d: d=%h expected=%h", i, d, exp_d);
         end
      end
   endtask

   task automatic test_boundary();
      en  = 1'b1;
      sel = 4'd0;
      settle();
      checks++;
      if (d !== 16'h0001) begin
         errors++;
         $display("FAIL boundary_sel0: d=%h expected=%h", d, 16'h0001);
      end
      sel = 4'd15;
      settle();
      checks++;
      if (d !== 16'h8000) begin
         errors++;
         $display("FAIL boundary_sel15: d=%h expected=%h", d, 16'h8000);
      end
   endtask

   task automatic test_enable_drop();
      en  = 1'b1;
      sel = 4'd5;
      settle();
      checks++;
      if (d !== 16'h0020) begin
         errors++;
         $display("FAIL en_sel5: d=%h expected=%h", d, 16'h0020);
      end
      en = 1'b0;
      settle();
      checks++;
      if (d !== 16'h0000) begin
         errors++;
         $display("FAIL en_drop: d=%h expected=%h", d, 16'h0000);
      end
      for (int i = 0; i < 4; i++) begin
         sel = 4'(3 * i + 7);
         settle();
         checks++;
         if (d !== 16'h0000) begin
            errors++;
            $display("FAIL en0_sel%0d: d=%h expected=%h", 3 * i + 7, d, 16'h0000);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [15:0] exp_rst;
`ifdef DMUX4X16_COMB_OUT_EN
      exp_rst = 16'h0400;
`else
      exp_rst = 16'h0000;
`endif
      en  = 1'b1;
      sel = 4'd10;
      settle();
      checks++;
      if (d !== 16'h0400) begin
         errors++;
         $display("FAIL pre_reset: d=%h expected=%h", d, 16'h0400);
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (d !== exp_rst) begin
         errors++;
         $display("FAIL async_reset_midcycle: d=%h expected=%h", d, exp_rst);
      end
      @(posedge clk);
      #1;
      checks++;
      if (d !== exp_rst) begin
         errors++;
         $display("FAIL reset_held_edge: d=%h expected=%h", d, exp_rst);
      end
      rst = 1'b0;
      settle();
      checks++;
      if (d !== 16'h0400) begin
         errors++;
         $display("FAIL reset_reload: d=%h expected=%h", d, 16'h0400);
      end
   endtask

   task automatic test_random();
      logic [15:0] exp_d;
      for (int n = 0; n < 40; n++) begin
         en    = 1'($urandom_range(0, 1));
         sel   = 4'($urandom_range(0, 15));
         exp_d = en ? (16'h0001 << sel) : 16'h0000;
         settle();
         checks++;
         if (d !== exp_d) begin
            errors++;
            $display("FAIL random_value en=%b sel=%0d: d=%h expected=%h", en, sel, d, exp_d);
         end
         checks++;
         if ($countones(d) != int'(en)) begin
            errors++;
            $display("FAIL random_onehot en=%b: countones=%0d expected=%0d", en, $countones(d), en);
         end
         checks++;
         if (d !== dmux4x16_pkg::decode(en, sel)) begin
            errors++;
            $display("FAIL random_pkg_decode en=%b sel=%0d: d=%h decode=%h", en, sel, d,
                     dmux4x16_pkg::decode(en, sel));
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_sweep();
      test_boundary();
      test_enable_drop();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
